// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory arbiter.
// Optional feature macro: MEM_ARB_RR_EN (round-robin arbitration).
package mem_arb_pkg;

  localparam int unsigned ADRS_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned LAT_W  = 3;   // holds latencies 1..7

  // Arbiter FSM encoding
  localparam logic [0:0] ARB_IDLE = 1'b0;
  localparam logic [0:0] ARB_WAIT = 1'b1;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } t_arb_owner;

  typedef struct packed {
    logic [ADRS_W-1:0] adrs;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic [BE_W-1:0]   byt_en;
    logic              sign_ext;
  } t_mem_req;

endpackage

// File: rtl/mem_arb_if.sv
// Bus bundle between fetch/data requesters, the arbiter and the unified memory.
// master: requester + memory side (drives requests and mem_rd_data).
// slave : arbiter side (drives grants, responses and mem_* controls).
interface mem_arb_if;
  import mem_arb_pkg::*;

  // fetch port
  logic              if_req;
  logic [ADRS_W-1:0] if_adrs;
  logic              if_gnt;
  logic              if_rsp_vld;
  logic [DATA_W-1:0] if_rd_data;
  // data port
  logic              dm_req;
  logic              dm_wr_en;
  logic [ADRS_W-1:0] dm_adrs;
  logic [DATA_W-1:0] dm_wr_data;
  logic [BE_W-1:0]   dm_byt_en;
  logic              dm_sign_ext;
  logic              dm_gnt;
  logic              dm_rsp_vld;
  logic [DATA_W-1:0] dm_rd_data;
  // memory port
  logic [ADRS_W-1:0] mem_adrs;
  logic              mem_wr_en;
  logic [DATA_W-1:0] mem_wr_data;
  logic [BE_W-1:0]   mem_byt_en;
  logic              mem_sign_ext;
  logic [DATA_W-1:0] mem_rd_data;

  modport master (
    output if_req, if_adrs,
    output dm_req, dm_wr_en, dm_adrs, dm_wr_data, dm_byt_en, dm_sign_ext,
    output mem_rd_data,
    input  if_gnt, if_rsp_vld, if_rd_data,
    input  dm_gnt, dm_rsp_vld, dm_rd_data,
    input  mem_adrs, mem_wr_en, mem_wr_data, mem_byt_en, mem_sign_ext
  );

  modport slave (
    input  if_req, if_adrs,
    input  dm_req, dm_wr_en, dm_adrs, dm_wr_data, dm_byt_en, dm_sign_ext,
    input  mem_rd_data,
    output if_gnt, if_rsp_vld, if_rd_data,
    output dm_gnt, dm_rsp_vld, dm_rd_data,
    output mem_adrs, mem_wr_en, mem_wr_data, mem_byt_en, mem_sign_ext
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner select between fetch and data requests.
// Ports: en_i (grant slot open), if_req_i, dm_req_i, if_favored_i (fetch
// wins a collision), if_win_o / dm_win_o (one-hot or zero).
module mem_arb_pick (
  input  logic en_i,
  input  logic if_req_i,
  input  logic dm_req_i,
  input  logic if_favored_i,
  output logic if_win_o,
  output logic dm_win_o
);

  // Data wins by default; fetch takes a collision only when favoured.
  always_comb begin
    if_win_o = 1'b0;
    dm_win_o = 1'b0;
    if (en_i) begin
      if (dm_req_i && !(if_req_i && if_favored_i)) dm_win_o = 1'b1;
      else if (if_req_i)                           if_win_o = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arb.sv
// Shares one single-port fixed-latency memory between fetch (IF) and data (DM).
// Ports: clk, rst_n (async, active-low), bus (mem_arb_if.slave: requests,
// grants, responses and the memory control/address/data lines).
// Parameters: MEM_RD_LAT (1..7) read latency, STARVE_MAX data grants tolerated
// while fetch waits. Macro MEM_ARB_RR_EN selects strict round-robin instead.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_RD_LAT = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  mem_arb_if.slave bus
);

  logic [0:0]        state_q, state_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  t_arb_owner        owner_q, owner_d;
  logic [ADRS_W-1:0] adrs_q, adrs_d;
  logic [BE_W-1:0]   byt_en_q, byt_en_d;
  logic              sign_ext_q, sign_ext_d;

  logic     last_cyc_c, grant_ok_c, if_favored_c;
  logic     if_win_c, dm_win_c, rd_grant_c;
  t_mem_req win_req_c;

  // Final latency cycle: response is due and a new grant may overlap it.
  assign last_cyc_c = (state_q == ARB_WAIT) && (lat_q == LAT_W'(MEM_RD_LAT));
  // Grants are suppressed while reset is held.
  assign grant_ok_c = rst_n && ((state_q == ARB_IDLE) || last_cyc_c);
  assign rd_grant_c = if_win_c || (dm_win_c && !bus.dm_wr_en);

`ifdef MEM_ARB_RR_EN
  // Round-robin: the last granted owner yields the next collision.
  t_arb_owner last_q, last_d;

  assign if_favored_c = (last_q == OWN_DM);

  always_comb begin
    last_d = last_q;
    if (dm_win_c)      last_d = OWN_DM;
    else if (if_win_c) last_d = OWN_IF;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= OWN_IF;
    else        last_q <= last_d;
  end
`else
  // Starvation counter: data grants taken while fetch was waiting.
  localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);
  logic [STARVE_W-1:0] starve_q, starve_d;

  assign if_favored_c = (starve_q == STARVE_W'(STARVE_MAX));

  always_comb begin
    starve_d = starve_q;
    if (!bus.if_req || if_win_c)
      starve_d = '0;
    else if (dm_win_c && (starve_q != STARVE_W'(STARVE_MAX)))
      starve_d = starve_q + STARVE_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) starve_q <= '0;
    else        starve_q <= starve_d;
  end
`endif

  mem_arb_pick u_pick (
    .en_i         (grant_ok_c),
    .if_req_i     (bus.if_req),
    .dm_req_i     (bus.dm_req),
    .if_favored_i (if_favored_c),
    .if_win_o     (if_win_c),
    .dm_win_o     (dm_win_c)
  );

  // Winner's request fields; fetch is always a full-word read.
  always_comb begin
    win_req_c = '0;
    if (dm_win_c) begin
      win_req_c.adrs     = bus.dm_adrs;
      win_req_c.wr_en    = bus.dm_wr_en;
      win_req_c.wr_data  = bus.dm_wr_data;
      win_req_c.byt_en   = bus.dm_byt_en;
      win_req_c.sign_ext = bus.dm_sign_ext;
    end else if (if_win_c) begin
      win_req_c.adrs   = bus.if_adrs;
      win_req_c.byt_en = '1;
    end
  end

  // Grants, response routing and memory drive.
  always_comb begin
    bus.if_gnt     = if_win_c;
    bus.dm_gnt     = dm_win_c;
    bus.if_rsp_vld = last_cyc_c && (owner_q == OWN_IF);
    bus.dm_rsp_vld = last_cyc_c && (owner_q == OWN_DM);
    bus.if_rd_data = '0;
    bus.dm_rd_data = '0;
    if (last_cyc_c && (owner_q == OWN_IF)) bus.if_rd_data = bus.mem_rd_data;
    if (last_cyc_c && (owner_q == OWN_DM)) bus.dm_rd_data = bus.mem_rd_data;

    if (if_win_c || dm_win_c) begin
      bus.mem_adrs     = win_req_c.adrs;
      bus.mem_wr_en    = win_req_c.wr_en;
      bus.mem_wr_data  = win_req_c.wr_data;
      bus.mem_byt_en   = win_req_c.byt_en;
      bus.mem_sign_ext = win_req_c.sign_ext;
    end else begin
      bus.mem_adrs     = adrs_q;
      bus.mem_wr_en    = 1'b0;
      bus.mem_wr_data  = '0;
      bus.mem_byt_en   = (state_q == ARB_WAIT) ? byt_en_q : '0;
      bus.mem_sign_ext = sign_ext_q;
    end
  end

  // Next state: a read grant (re)starts the latency count and captures its fields.
  always_comb begin
    state_d    = state_q;
    lat_d      = lat_q;
    owner_d    = owner_q;
    adrs_d     = adrs_q;
    byt_en_d   = byt_en_q;
    sign_ext_d = sign_ext_q;
    if (last_cyc_c)                 state_d = ARB_IDLE;
    else if (state_q == ARB_WAIT)   lat_d   = lat_q + LAT_W'(1);
    if (rd_grant_c) begin
      state_d    = ARB_WAIT;
      lat_d      = LAT_W'(1);
      owner_d    = dm_win_c ? OWN_DM : OWN_IF;
      adrs_d     = win_req_c.adrs;
      byt_en_d   = win_req_c.byt_en;
      sign_ext_d = win_req_c.sign_ext;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ARB_IDLE;
      lat_q      <= '0;
      owner_q    <= OWN_IF;
      adrs_q     <= '0;
      byt_en_q   <= '0;
      sign_ext_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lat_q      <= lat_d;
      owner_q    <= owner_d;
      adrs_q     <= adrs_d;
      byt_en_q   <= byt_en_d;
      sign_ext_q <= sign_ext_d;
    end
  end

endmodule

// File: tb/tb_mem_arb.sv
// Self-checking bench for mem_arb: directed vector table, hand sequences for
// multi-cycle corners (latency 1 and 3 instances) and randomized traffic
// against a transaction-level reference model.
module tb_mem_arb;
  import mem_arb_pkg::*;

  localparam int unsigned LAT_A = 1;
  localparam int unsigned LAT_B = 3;
  localparam int unsigned SMAX  = 4;
  localparam int          N_RND = 1500;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_arb_if bus_a ();
  mem_arb_if bus_b ();

  mem_arb #(.MEM_RD_LAT(LAT_A), .STARVE_MAX(SMAX)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  mem_arb #(.MEM_RD_LAT(LAT_B), .STARVE_MAX(SMAX)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  // Memory content is a fixed function of the address.
  function automatic logic [31:0] rom(input logic [31:0] a);
    return a ^ 32'h0000_0003;
  endfunction

  // Fixed-latency memory models
  logic [31:0] pipe_a = '0;
  logic [31:0] pipe_b [3] = '{default: '0};
  always @(posedge clk) begin
    pipe_a    <= rom(bus_a.mem_adrs);
    pipe_b[0] <= rom(bus_b.mem_adrs);
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign bus_a.mem_rd_data = pipe_a;
  assign bus_b.mem_rd_data = pipe_b[2];

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    bus_a.if_req = 1'b0; bus_a.if_adrs = '0;
    bus_a.dm_req = 1'b0; bus_a.dm_wr_en = 1'b0; bus_a.dm_adrs = '0;
    bus_a.dm_wr_data = '0; bus_a.dm_byt_en = '0; bus_a.dm_sign_ext = 1'b0;
  endtask

  task automatic idle_b();
    bus_b.if_req = 1'b0; bus_b.if_adrs = '0;
    bus_b.dm_req = 1'b0; bus_b.dm_wr_en = 1'b0; bus_b.dm_adrs = '0;
    bus_b.dm_wr_data = '0; bus_b.dm_byt_en = '0; bus_b.dm_sign_ext = 1'b0;
  endtask

  typedef struct {
    logic        if_req;
    logic [31:0] if_adrs;
    logic        dm_req;
    logic        dm_wr;
    logic [31:0] dm_adrs;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_be;
    logic        dm_sx;
    logic        e_ig;
    logic        e_dg;
    logic        e_wr;
    logic [31:0] e_adrs;
    logic [3:0]  e_be;
    logic        e_sx;
    logic        chk_fld;
    logic        chk_be;
  } vec_t;

  vec_t vt [8];

  typedef struct {
    int          due;
    logic        own_dm;
    logic [31:0] data;
  } pend_t;

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : main
    int          n_dm;
    logic        got_if;
    int          exp_dm;
    pend_t       pq[$];
    int          starve;
    logic        last_dm;
    logic        e_ig, e_dg, e_ir, e_dr, was_empty, prefer_if, ig_prev, dg_prev;
    logic [31:0] e_id, e_dd;

    // ---------------- reset state, requests asserted during reset
    idle_a(); idle_b();
    bus_a.if_req = 1'b1; bus_a.if_adrs = 32'h40;
    bus_a.dm_req = 1'b1; bus_a.dm_wr_en = 1'b1; bus_a.dm_adrs = 32'h80;
    bus_a.dm_byt_en = 4'hF; bus_a.dm_wr_data = 32'h1;
    #3;
    chk("rst_if_gnt",   bus_a.if_gnt,     0);
    chk("rst_dm_gnt",   bus_a.dm_gnt,     0);
    chk("rst_if_rsp",   bus_a.if_rsp_vld, 0);
    chk("rst_dm_rsp",   bus_a.dm_rsp_vld, 0);
    chk("rst_if_data",  bus_a.if_rd_data, 0);
    chk("rst_dm_data",  bus_a.dm_rd_data, 0);
    chk("rst_mem_wr",   bus_a.mem_wr_en,  0);
    chk("rst_mem_be",   bus_a.mem_byt_en, 0);
    chk("rst_mem_adrs", bus_a.mem_adrs,   0);
    idle_a();
    cyc();
    rst_n = 1'b1;

    // ---------------- vector table, each applied from IDLE
    vt[0] = '{0, 32'h0,  0, 0, 32'h0,   32'h0,        4'h0, 0,  0, 0, 0, 32'h0,   4'h0, 0, 0, 1};
    vt[1] = '{0, 32'h0,  1, 0, 32'h200, 32'h0,        4'hF, 0,  0, 1, 0, 32'h200, 4'hF, 0, 1, 1};
    vt[2] = '{1, 32'h10, 0, 0, 32'h0,   32'h0,        4'h0, 0,  1, 0, 0, 32'h10,  4'h0, 0, 1, 0};
    vt[3] = '{1, 32'h20, 1, 0, 32'h240, 32'h0,        4'hC, 0,  0, 1, 0, 32'h240, 4'hC, 0, 1, 1};
    vt[4] = '{1, 32'h14, 0, 0, 32'h0,   32'h0,        4'h0, 0,  1, 0, 0, 32'h14,  4'h0, 0, 1, 0};
    vt[5] = '{1, 32'h30, 1, 1, 32'h340, 32'h12345678, 4'hF, 0,  0, 1, 1, 32'h340, 4'hF, 0, 1, 1};
    vt[6] = '{0, 32'h0,  1, 1, 32'h100, 32'hDEADBEEF, 4'h3, 0,  0, 1, 1, 32'h100, 4'h3, 0, 1, 1};
    vt[7] = '{0, 32'h0,  1, 0, 32'h104, 32'h0,        4'h1, 1,  0, 1, 0, 32'h104, 4'h1, 1, 1, 1};

    for (int i = 0; i < 8; i++) begin
      cyc();
      bus_a.if_req = vt[i].if_req; bus_a.if_adrs = vt[i].if_adrs;
      bus_a.dm_req = vt[i].dm_req; bus_a.dm_wr_en = vt[i].dm_wr;
      bus_a.dm_adrs = vt[i].dm_adrs; bus_a.dm_wr_data = vt[i].dm_wdata;
      bus_a.dm_byt_en = vt[i].dm_be; bus_a.dm_sign_ext = vt[i].dm_sx;
      #1;
      chk($sformatf("tbl%0d_if_gnt", i), bus_a.if_gnt,    vt[i].e_ig);
      chk($sformatf("tbl%0d_dm_gnt", i), bus_a.dm_gnt,    vt[i].e_dg);
      chk($sformatf("tbl%0d_wr_en", i),  bus_a.mem_wr_en, vt[i].e_wr);
      if (vt[i].chk_be)  chk($sformatf("tbl%0d_be", i),   bus_a.mem_byt_en,   vt[i].e_be);
      if (vt[i].chk_fld) chk($sformatf("tbl%0d_adrs", i), bus_a.mem_adrs,     vt[i].e_adrs);
      if (vt[i].chk_fld) chk($sformatf("tbl%0d_sx", i),   bus_a.mem_sign_ext, vt[i].e_sx);
      if (vt[i].e_wr)    chk($sformatf("tbl%0d_wdata", i), bus_a.mem_wr_data, vt[i].dm_wdata);
      cyc();
      idle_a();
      #1;
      chk($sformatf("tbl%0d_if_rsp", i), bus_a.if_rsp_vld, vt[i].e_ig);
      chk($sformatf("tbl%0d_dm_rsp", i), bus_a.dm_rsp_vld, vt[i].e_dg && !vt[i].e_wr);
      chk($sformatf("tbl%0d_if_data", i), bus_a.if_rd_data, vt[i].e_ig ? rom(vt[i].if_adrs) : 32'h0);
      chk($sformatf("tbl%0d_dm_data", i), bus_a.dm_rd_data,
          (vt[i].e_dg && !vt[i].e_wr) ? rom(vt[i].dm_adrs) : 32'h0);
      cyc(); cyc();
    end

    // ---------------- IF read, latency 1: 0x10 -> 0x13
    cyc();
    bus_a.if_req = 1'b1; bus_a.if_adrs = 32'h10;
    #1;
    chk("ifrd_gnt",    bus_a.if_gnt,     1);
    chk("ifrd_rsp_T",  bus_a.if_rsp_vld, 0);
    cyc();
    idle_a();
    #1;
    chk("ifrd_rsp",    bus_a.if_rsp_vld, 1);
    chk("ifrd_data",   bus_a.if_rd_data, 32'h13);
    chk("ifrd_dm_rsp", bus_a.dm_rsp_vld, 0);
    cyc(); cyc();

    // ---------------- collision: DM read wins, IF granted on the response cycle
    cyc();
    bus_a.if_req = 1'b1; bus_a.if_adrs = 32'h20;
    bus_a.dm_req = 1'b1; bus_a.dm_wr_en = 1'b0; bus_a.dm_adrs = 32'h40; bus_a.dm_byt_en = 4'hF;
    #1;
    chk("col_dm_gnt", bus_a.dm_gnt, 1);
    chk("col_if_gnt", bus_a.if_gnt, 0);
    cyc();
    bus_a.dm_req = 1'b0;
    #1;
    chk("col_dm_rsp",  bus_a.dm_rsp_vld, 1);
    chk("col_dm_data", bus_a.dm_rd_data, 32'h43);
    chk("col_if_gnt2", bus_a.if_gnt,     1);
    chk("col_if_rsp0", bus_a.if_rsp_vld, 0);
    cyc();
    idle_a();
    #1;
    chk("col_if_rsp",  bus_a.if_rsp_vld, 1);
    chk("col_if_data", bus_a.if_rd_data, 32'h23);
    chk("col_dm_rsp1", bus_a.dm_rsp_vld, 0);
    cyc(); cyc();

    // ---------------- starvation: back-to-back DM writes with fetch pending
`ifdef MEM_ARB_RR_EN
    exp_dm = 1;
`else
    exp_dm = int'(SMAX);
`endif
    cyc();
    bus_a.if_req = 1'b1; bus_a.if_adrs = 32'h80;
    bus_a.dm_req = 1'b1; bus_a.dm_wr_en = 1'b1; bus_a.dm_adrs = 32'h300;
    bus_a.dm_wr_data = 32'hA5A5_0000; bus_a.dm_byt_en = 4'hF;
    n_dm = 0;
    got_if = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) cyc();
      #1;
      if (bus_a.if_gnt) begin
        got_if = 1'b1;
        break;
      end
      if (bus_a.dm_gnt) n_dm++;
    end
    chk("starve_if_gnt",  got_if,       1);
    chk("starve_dm_cnt",  n_dm,         exp_dm);
    chk("starve_dm_gnt0", bus_a.dm_gnt, 0);
    cyc();
    idle_a();
    #1;
    chk("starve_if_rsp",  bus_a.if_rsp_vld, 1);
    chk("starve_if_data", bus_a.if_rd_data, 32'h83);
    cyc(); cyc();

    // ---------------- latency 3, reset at T+2 drops the pending read
    cyc();
    bus_b.if_req = 1'b1; bus_b.if_adrs = 32'h44;
    #1;
    chk("l3_if_gnt", bus_b.if_gnt, 1);
    cyc();
    idle_b();
    #1;
    chk("l3_rsp_T1", bus_b.if_rsp_vld, 0);
    cyc();
    rst_n = 1'b0;
    bus_b.dm_req = 1'b1; bus_b.dm_wr_en = 1'b1; bus_b.dm_adrs = 32'h500;
    bus_b.dm_wr_data = 32'h55; bus_b.dm_byt_en = 4'hF;
    #1;
    chk("l3_rst_dm_gnt", bus_b.dm_gnt,     0);
    chk("l3_rst_if_gnt", bus_b.if_gnt,     0);
    chk("l3_rst_wr_en",  bus_b.mem_wr_en,  0);
    chk("l3_rst_if_rsp", bus_b.if_rsp_vld, 0);
    cyc();
    rst_n = 1'b1;
    #1;
    chk("l3_post_dm_gnt", bus_b.dm_gnt,    1);
    chk("l3_post_wr_en",  bus_b.mem_wr_en, 1);
    for (int k = 0; k < 5; k++) begin
      cyc();
      idle_b();
      #1;
      chk($sformatf("l3_dropped_if_rsp%0d", k), bus_b.if_rsp_vld, 0);
      chk($sformatf("l3_dropped_dm_rsp%0d", k), bus_b.dm_rsp_vld, 0);
    end
    cyc();
    bus_b.dm_req = 1'b1; bus_b.dm_wr_en = 1'b0; bus_b.dm_adrs = 32'h88; bus_b.dm_byt_en = 4'hF;
    #1;
    chk("l3_rd_gnt", bus_b.dm_gnt, 1);
    for (int k = 1; k <= int'(LAT_B); k++) begin
      cyc();
      idle_b();
      #1;
      chk($sformatf("l3_rd_rsp_T%0d", k),  bus_b.dm_rsp_vld, (k == int'(LAT_B)) ? 1 : 0);
      chk($sformatf("l3_rd_data_T%0d", k), bus_b.dm_rd_data, (k == int'(LAT_B)) ? 32'h8B : 32'h0);
      chk($sformatf("l3_rd_if_rsp_T%0d", k), bus_b.if_rsp_vld, 0);
    end

    // ---------------- randomized traffic against the reference model
    cyc();
    rst_n = 1'b0;
    idle_a(); idle_b();
    cyc();
    rst_n = 1'b1;
    starve  = 0;
    last_dm = 1'b0;
    ig_prev = 1'b0;
    dg_prev = 1'b0;
    for (int t = 0; t < N_RND; t++) begin
      cyc();
      // fetch requester: hold until granted, occasionally withdraw
      if (bus_a.if_req && !ig_prev && ($urandom_range(15) == 0)) bus_a.if_req = 1'b0;
      else if (!bus_a.if_req || ig_prev) begin
        bus_a.if_req  = 1'($urandom_range(1));
        bus_a.if_adrs = $urandom() & 32'hFFFF_FFFC;
      end
      // data requester
      if (bus_a.dm_req && !dg_prev && ($urandom_range(15) == 0)) bus_a.dm_req = 1'b0;
      else if (!bus_a.dm_req || dg_prev) begin
        bus_a.dm_req      = 1'($urandom_range(1));
        bus_a.dm_wr_en    = 1'($urandom_range(1));
        bus_a.dm_adrs     = $urandom();
        bus_a.dm_wr_data  = $urandom();
        bus_a.dm_byt_en   = 4'($urandom_range(15));
        bus_a.dm_sign_ext = 1'($urandom_range(1));
      end
      #1;
      e_ir = 1'b0; e_dr = 1'b0; e_id = '0; e_dd = '0;
      was_empty = (pq.size() == 0);
      if (!was_empty && pq[0].due == t) begin
        if (pq[0].own_dm) begin e_dr = 1'b1; e_dd = pq[0].data; end
        else              begin e_ir = 1'b1; e_id = pq[0].data; end
        pq.delete(0);
      end
      e_ig = 1'b0; e_dg = 1'b0;
      if (pq.size() == 0) begin
`ifdef MEM_ARB_RR_EN
        prefer_if = last_dm;
`else
        prefer_if = (starve == int'(SMAX));
`endif
        if (bus_a.dm_req && !(bus_a.if_req && prefer_if)) e_dg = 1'b1;
        else if (bus_a.if_req)                            e_ig = 1'b1;
      end
      if (e_dg && !bus_a.dm_wr_en) pq.push_back('{t + int'(LAT_A), 1'b1, rom(bus_a.dm_adrs)});
      if (e_ig)                    pq.push_back('{t + int'(LAT_A), 1'b0, rom(bus_a.if_adrs)});

      chk("rnd_if_gnt",  bus_a.if_gnt,     e_ig);
      chk("rnd_dm_gnt",  bus_a.dm_gnt,     e_dg);
      chk("rnd_if_rsp",  bus_a.if_rsp_vld, e_ir);
      chk("rnd_dm_rsp",  bus_a.dm_rsp_vld, e_dr);
      chk("rnd_if_data", bus_a.if_rd_data, e_id);
      chk("rnd_dm_data", bus_a.dm_rd_data, e_dd);
      chk("rnd_wr_en",   bus_a.mem_wr_en,  e_dg && bus_a.dm_wr_en);
      if (e_dg) chk("rnd_dm_adrs", bus_a.mem_adrs, bus_a.dm_adrs);
      if (e_ig) chk("rnd_if_adrs", bus_a.mem_adrs, bus_a.if_adrs);
      if (e_dg && bus_a.dm_wr_en) chk("rnd_wdata", bus_a.mem_wr_data, bus_a.dm_wr_data);
      if (e_dg) chk("rnd_be", bus_a.mem_byt_en, bus_a.dm_byt_en);
      if (was_empty && !e_ig && !e_dg) chk("rnd_idle_be", bus_a.mem_byt_en, 0);

      if (!bus_a.if_req || e_ig) starve = 0;
      else if (e_dg && starve < int'(SMAX)) starve++;
      if (e_dg)      last_dm = 1'b1;
      else if (e_ig) last_dm = 1'b0;
      ig_prev = e_ig;
      dg_prev = e_dg;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
